// File: rtl/conv_window_sequencer.sv
// Address/control sequencer that walks a KxK window over one feature-map plane,
// issuing one input/weight address per tap and pipeline-aligned MAC/output strobes.
module conv_window_sequencer #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int ADDR_W   = 10,
  parameter int WADDR_W  = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               acc_clr,
  output logic               acc_en,
  output logic               out_load,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam int OW = (IMG_W - K) / STRIDE + 1;
  localparam int OH = (IMG_H - K) / STRIDE + 1;
  localparam int HW = ADDR_W / 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [HW-1:0] oy;
    logic [HW-1:0] ox;
  } sb_t;

  state_t             state, state_nx;
  logic [WADDR_W-1:0] kx, ky;
  logic [HW-1:0]      ox, oy;
  sb_t                sr [PIPE_LAT];
  sb_t                sb_in;
  logic               kx_end, ky_end, ox_end, oy_end, last_tap, drain_empty;

  // Handshake: start is a one-cycle request honoured only in IDLE with stall low;
  // stall high blocks every register update, so a strobe held across stall is one event.
  assign kx_end   = (kx == WADDR_W'(K - 1));
  assign ky_end   = (ky == WADDR_W'(K - 1));
  assign ox_end   = (ox == HW'(OW - 1));
  assign oy_end   = (oy == HW'(OH - 1));
  assign last_tap = kx_end && ky_end && ox_end && oy_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_tap) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_empty) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (stall) state_nx = state;
  end

  // kx innermost, then ky, ox, oy; all wrap to zero after the final tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (!stall) begin
      if (state == S_IDLE) begin
        kx <= '0;
        ky <= '0;
        ox <= '0;
        oy <= '0;
      end else if (state == S_RUN) begin
        if (!kx_end) kx <= kx + WADDR_W'(1);
        else begin
          kx <= '0;
          if (!ky_end) ky <= ky + WADDR_W'(1);
          else begin
            ky <= '0;
            if (!ox_end) ox <= ox + HW'(1);
            else begin
              ox <= '0;
              oy <= oy_end ? '0 : oy + HW'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    sb_in.valid = (state == S_RUN);
    sb_in.first = (kx == '0) && (ky == '0);
    sb_in.last  = kx_end && ky_end;
    sb_in.oy    = oy;
    sb_in.ox    = ox;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
    end else if (!stall) begin
      sr[0] <= sb_in;
      for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  // Only a bubble shifts in during DRAIN, so after the next shift the register
  // is empty exactly when every entry but the tail is already invalid.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < PIPE_LAT - 1; i++)
      if (sr[i].valid) drain_empty = 1'b0;
  end

  always_comb begin
    in_addr = '0;
    w_addr  = '0;
    if (state == S_RUN) begin
      in_addr = ADDR_W'((32'(oy) * STRIDE + 32'(ky)) * IMG_W + 32'(ox) * STRIDE + 32'(kx));
      w_addr  = WADDR_W'(32'(ky) * K + 32'(kx));
    end
  end

  assign acc_en    = sr[PIPE_LAT-1].valid;
  assign acc_clr   = sr[PIPE_LAT-1].valid && sr[PIPE_LAT-1].first;
  assign out_load  = sr[PIPE_LAT-1].valid && sr[PIPE_LAT-1].last;
  assign out_addr  = ADDR_W'({sr[PIPE_LAT-1].oy, sr[PIPE_LAT-1].ox});
  assign dbg_state = state;

endmodule
